// File: rtl/controller_source_arbiter.sv
// Arbitrates the console button path between button board, N64 and remote receivers.
// Round-robin grant on activity, idle-timeout release, and a lock mode that pins the owner.
module controller_source_arbiter #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] b_board_in,
  input  logic [WIDTH-1:0] N64_in,
  input  logic [WIDTH-1:0] remote_in,
  input  logic [2:0]       src_en,
  input  logic             lock_en,
  input  logic [1:0]       lock_src,
  output logic [WIDTH-1:0] btn_out,
  output logic [1:0]       owner,
  output logic             owner_valid,
  output logic             switch_pulse
);

  typedef enum logic [1:0] {StIdle, StOwned, StLocked} state_e;

  localparam logic [1:0]       NoOwner  = 2'd3;
  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] btn_q, btn_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] idle_q, idle_d;

  logic [WIDTH-1:0] src [3];
  logic [2:0]       active;
  logic [WIDTH-1:0] owner_vec, lock_vec, grant_vec;
  logic             owner_en, grant_any;
  logic [1:0]       grant_idx;

  assign src[0] = b_board_in;
  assign src[1] = N64_in;
  assign src[2] = remote_in;

  always_comb begin
    active    = '0;
    owner_vec = '0;
    lock_vec  = '0;
    owner_en  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      active[k] = (src[k] != '0) && src_en[k];
      if (owner_q == 2'(k)) begin
        owner_vec = src[k];
        owner_en  = src_en[k];
      end
      if (lock_src == 2'(k)) lock_vec = src[k];
    end
  end

  // Search order starts one past the last released owner.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = NoOwner;
    grant_vec = '0;
    for (int i = 1; i <= 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (!grant_any && active[k] && ((int'(last_q) + i) % 3 == k)) begin
          grant_any = 1'b1;
          grant_idx = 2'(k);
          grant_vec = src[k];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    idle_d  = idle_q;
    btn_d   = btn_q;
    if (lock_en) begin
      state_d = StLocked;
      owner_d = lock_src;
      btn_d   = lock_vec;
      idle_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          btn_d = '0;
          if (grant_any) begin
            state_d = StOwned;
            owner_d = grant_idx;
            btn_d   = grant_vec;
            idle_d  = '0;
          end
        end
        StOwned: begin
          btn_d = owner_vec;
          if (!owner_en || (owner_vec == '0 && idle_q == IdleLast)) begin
            state_d = StIdle;
            owner_d = NoOwner;
            btn_d   = '0;
            last_d  = owner_q;
            idle_d  = '0;
          end else if (owner_vec == '0) begin
            idle_d = idle_q + 1'b1;
          end else begin
            idle_d = '0;
          end
        end
        StLocked: begin
          idle_d = '0;
          if (owner_q != NoOwner) begin
            state_d = StOwned;
            btn_d   = owner_vec;
          end else begin
            state_d = StIdle;
            btn_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          owner_d = NoOwner;
          btn_d   = '0;
        end
      endcase
    end
    pulse_d = (owner_d != owner_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      btn_q   <= '0;
      owner_q <= NoOwner;
      last_q  <= 2'd2;
      pulse_q <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      pulse_q <= pulse_d;
      idle_q  <= idle_d;
    end
  end

  assign btn_out      = btn_q;
  assign owner        = owner_q;
  assign owner_valid  = (owner_q != NoOwner);
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_controller_source_arbiter.sv
// Bench for controller_source_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a behavioural model.
module tb_controller_source_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] b_board_in = '0, N64_in = '0, remote_in = '0;
  logic [2:0]  src_en = 3'b111;
  logic        lock_en = 1'b0;
  logic [1:0]  lock_src = 2'd0;
  logic [11:0] btn_out;
  logic [1:0]  owner;
  logic        owner_valid, switch_pulse;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  // Model state: owner as plain int (3 = none), consecutive-zero streak of the owner.
  int          m_owner = 3, m_last = 2, m_streak = 0;
  bit          m_locked = 1'b0, m_pulse = 1'b0;
  logic [11:0] m_btn = '0;

  controller_source_arbiter #(.WIDTH(12), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .b_board_in   (b_board_in),
    .N64_in       (N64_in),
    .remote_in    (remote_in),
    .src_en       (src_en),
    .lock_en      (lock_en),
    .lock_src     (lock_src),
    .btn_out      (btn_out),
    .owner        (owner),
    .owner_valid  (owner_valid),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    logic [11:0] v [3];
    int prev;
    v[0] = b_board_in;
    v[1] = N64_in;
    v[2] = remote_in;
    prev = m_owner;
    if (reset) begin
      m_owner = 3; m_last = 2; m_streak = 0; m_locked = 1'b0; m_btn = '0; prev = 3;
    end else if (lock_en) begin
      m_locked = 1'b1;
      m_owner  = int'(lock_src);
      m_btn    = (m_owner == 3) ? 12'h000 : v[m_owner];
      m_streak = 0;
    end else if (m_locked) begin
      m_locked = 1'b0;
      m_btn    = (m_owner == 3) ? 12'h000 : v[m_owner];
      m_streak = 0;
    end else if (m_owner == 3) begin
      m_btn = '0;
      for (int i = 1; i <= 3; i++) begin
        int k;
        k = (m_last + i) % 3;
        if (m_owner == 3 && v[k] != 0 && src_en[k]) begin
          m_owner = k; m_btn = v[k]; m_streak = 0;
        end
      end
    end else begin
      m_btn = v[m_owner];
      if (!src_en[m_owner] || (v[m_owner] == 0 && m_streak + 1 >= TO)) begin
        m_last = m_owner; m_owner = 3; m_btn = '0; m_streak = 0;
      end else if (v[m_owner] == 0) begin
        m_streak++;
      end else begin
        m_streak = 0;
      end
    end
    m_pulse = (m_owner != prev);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("btn_out", 32'(btn_out), 32'(m_btn));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("owner_valid", 32'(owner_valid), 32'(m_owner != 3));
      chk("switch_pulse", 32'(switch_pulse), 32'(m_pulse));
    end
  end

  // Apply inputs, then return just after the edge that samples them.
  task automatic step(input logic [11:0] bb, input logic [11:0] n6, input logic [11:0] rm,
                      input logic [2:0] en, input logic le, input logic [1:0] ls,
                      input logic rst);
    b_board_in = bb; N64_in = n6; remote_in = rm;
    src_en = en; lock_en = le; lock_src = ls; reset = rst;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step(12'h0, 12'h0, 12'h0, 3'b111, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(12'h0, 12'h0, 12'h0, 3'b111, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    do_reset();
    chk_on = 1'b1;
    chk("reset owner", 32'(owner), 32'd3);
    chk("reset btn", 32'(btn_out), 32'h0);
    chk("reset valid", 32'(owner_valid), 32'd0);

    // Single source grant with one-cycle latency
    step(12'h0, 12'h040, 12'h0, 3'b111, 1'b0, 2'd0, 1'b0);
    chk("grant owner", 32'(owner), 32'd1);
    chk("grant btn", 32'(btn_out), 32'h040);
    chk("grant pulse", 32'(switch_pulse), 32'd1);
    step(12'h0, 12'h040, 12'h0, 3'b111, 1'b0, 2'd0, 1'b0);
    chk("pulse drops", 32'(switch_pulse), 32'd0);

    // Round robin from last_owner=2
    do_reset();
    step(12'h1, 12'h2, 12'h4, 3'b111, 1'b0, 2'd0, 1'b0);
    chk("rr first", 32'(owner), 32'd0);
    idle_steps(TO);
    chk("rr release", 32'(owner), 32'd3);
    step(12'h1, 12'h2, 12'h4, 3'b111, 1'b0, 2'd0, 1'b0);
    chk("rr second", 32'(owner), 32'd1);
    idle_steps(TO);
    step(12'h1, 12'h2, 12'h4, 3'b111, 1'b0, 2'd0, 1'b0);
    chk("rr third", 32'(owner), 32'd2);

    // Timeout release, then remote picks up
    do_reset();
    step(12'h1, 12'h0, 12'h0, 3'b111, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < TO - 1; i++) step(12'h0, 12'h0, 12'h010, 3'b111, 1'b0, 2'd0, 1'b0);
    chk("no preempt", 32'(owner), 32'd0);
    step(12'h0, 12'h0, 12'h010, 3'b111, 1'b0, 2'd0, 1'b0);
    chk("timeout owner", 32'(owner), 32'd3);
    chk("timeout pulse", 32'(switch_pulse), 32'd1);
    step(12'h0, 12'h0, 12'h010, 3'b111, 1'b0, 2'd0, 1'b0);
    chk("regrant owner", 32'(owner), 32'd2);
    chk("regrant btn", 32'(btn_out), 32'h010);

    // Enable release
    do_reset();
    step(12'h0, 12'h005, 12'h0, 3'b111, 1'b0, 2'd0, 1'b0);
    step(12'h0, 12'h005, 12'h0, 3'b101, 1'b0, 2'd0, 1'b0);
    chk("en release owner", 32'(owner), 32'd3);
    chk("en release btn", 32'(btn_out), 32'h0);
    chk("en release pulse", 32'(switch_pulse), 32'd1);

    // Lock overrides owner and timeout
    do_reset();
    step(12'h1, 12'h0, 12'h0, 3'b111, 1'b0, 2'd0, 1'b0);
    step(12'h1, 12'h0, 12'h0, 3'b111, 1'b1, 2'd2, 1'b0);
    chk("lock owner", 32'(owner), 32'd2);
    chk("lock pulse", 32'(switch_pulse), 32'd1);
    for (int i = 0; i < 20; i++) step(12'h1, 12'h0, 12'h0, 3'b000, 1'b1, 2'd2, 1'b0);
    chk("lock hold", 32'(owner), 32'd2);
    step(12'h0, 12'h0, 12'h0, 3'b111, 1'b0, 2'd2, 1'b0);
    chk("unlock owner", 32'(owner), 32'd2);
    idle_steps(TO - 1);
    chk("unlock restart", 32'(owner), 32'd2);
    idle_steps(1);
    chk("unlock timeout", 32'(owner), 32'd3);

    // Reset mid-operation
    do_reset();
    step(12'h0, 12'hFFF, 12'h0, 3'b111, 1'b0, 2'd0, 1'b0);
    step(12'h0, 12'hFFF, 12'h0, 3'b111, 1'b0, 2'd0, 1'b1);
    chk("midreset btn", 32'(btn_out), 32'h0);
    chk("midreset owner", 32'(owner), 32'd3);
    chk("midreset pulse", 32'(switch_pulse), 32'd0);

    // Random traffic; lock_src only moves while lock_en stays asserted or on entry
    begin
      logic le_cur, le_new;
      logic [1:0] ls_cur;
      logic [11:0] vv [3];
      logic [2:0] en;
      le_cur = 1'b0;
      ls_cur = 2'd0;
      for (int c = 0; c < 3000; c++) begin
        for (int k = 0; k < 3; k++)
          vv[k] = ($urandom_range(0, 9) < 6) ? 12'h0 : 12'($urandom);
        for (int k = 0; k < 3; k++) en[k] = ($urandom_range(0, 19) != 0);
        le_new = ($urandom_range(0, 24) == 0) ? ~le_cur : le_cur;
        if (le_new && (!le_cur || $urandom_range(0, 3) == 0)) ls_cur = 2'($urandom_range(0, 3));
        step(vv[0], vv[1], vv[2], en, le_new, ls_cur, ($urandom_range(0, 199) == 0));
        le_cur = le_new;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
